// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-requester write-back arbiter with per-requester FIFOs and registered bank write port
// Optional direct-issue path for an empty FIFO is enabled by defining WB_BYPASS_EN.
module wb_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_vec,
    input  logic [2:0]  req0_dir,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_vec,
    input  logic [2:0]  req1_dir,
    input  logic [31:0] req1_data,
    output logic        reg_wrv,
    output logic        reg_wrs,
    output logic [2:0]  i_dir_wr,
    output logic [31:0] data_wrv,
    output logic [7:0]  data_wrs,
    output logic        wb_idle
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = 36;

    logic [EW-1:0] mem_q [2][FIFO_DEPTH];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [PW-1:0] wp_q  [2];
    logic [PW-1:0] wp_d  [2];
    logic [PW-1:0] rp_q  [2];
    logic [PW-1:0] rp_d  [2];

    logic [EW-1:0] in_ent [2];
    logic [EW-1:0] head   [2];
    logic [1:0]    in_valid;
    logic [1:0]    ready;
    logic [1:0]    fifo_ne;
    logic [1:0]    byp;
    logic [1:0]    cand;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic          gnt_any;
    logic          gnt_sel;

    logic          last_q, last_d;
    logic          wrv_q, wrv_d;
    logic          wrs_q, wrs_d;
    logic [2:0]    dir_q, dir_d;
    logic [31:0]   data_q, data_d;

    assign in_ent[0] = {req0_vec, req0_dir, req0_data};
    assign in_ent[1] = {req1_vec, req1_dir, req1_data};
    assign in_valid  = {req1_valid, req0_valid};

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            ready[k]   = (cnt_q[k] < CW'(FIFO_DEPTH));
            fifo_ne[k] = (cnt_q[k] != '0);
`ifdef WB_BYPASS_EN
            byp[k]     = in_valid[k] && !fifo_ne[k];
`else
            byp[k]     = 1'b0;
`endif
            cand[k]    = fifo_ne[k] || byp[k];
            head[k]    = fifo_ne[k] ? mem_q[k][rp_q[k]] : in_ent[k];
        end
    end

    // With two candidates the one that did not win last time goes next.
    assign gnt_any = |cand;
    assign gnt_sel = (cand[0] && cand[1]) ? ~last_q : cand[1];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            pop[k]  = !flush && gnt_any && (gnt_sel == k[0]) && fifo_ne[k];
            // A request issued straight from the input never enters its FIFO.
            push[k] = !flush && in_valid[k] && ready[k]
                      && !(gnt_any && (gnt_sel == k[0]) && !fifo_ne[k]);
            if (flush) begin
                cnt_d[k] = '0;
                wp_d[k]  = '0;
                rp_d[k]  = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
                wp_d[k]  = push[k] ? wp_q[k] + 1'b1 : wp_q[k];
                rp_d[k]  = pop[k]  ? rp_q[k] + 1'b1 : rp_q[k];
            end
        end
    end

    always_comb begin
        last_d = last_q;
        wrv_d  = 1'b0;
        wrs_d  = 1'b0;
        dir_d  = dir_q;
        data_d = data_q;
        if (!flush && gnt_any) begin
            last_d = gnt_sel;
            wrv_d  = head[gnt_sel][35];
            wrs_d  = !head[gnt_sel][35];
            dir_d  = head[gnt_sel][34:32];
            data_d = head[gnt_sel][31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= '0;
                wp_q[k]  <= '0;
                rp_q[k]  <= '0;
            end
            last_q <= 1'b1;
            wrv_q  <= 1'b0;
            wrs_q  <= 1'b0;
            dir_q  <= '0;
            data_q <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= cnt_d[k];
                wp_q[k]  <= wp_d[k];
                rp_q[k]  <= rp_d[k];
            end
            last_q <= last_d;
            wrv_q  <= wrv_d;
            wrs_q  <= wrs_d;
            dir_q  <= dir_d;
            data_q <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (push[k]) begin
                mem_q[k][wp_q[k]] <= in_ent[k];
            end
        end
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign reg_wrv    = wrv_q;
    assign reg_wrs    = wrs_q;
    assign i_dir_wr   = dir_q;
    assign data_wrv   = data_q;
    assign data_wrs   = data_q[7:0];
    assign wb_idle    = !fifo_ne[0] && !fifo_ne[1] && !wrv_q && !wrs_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

`ifdef WB_BYPASS_EN
    localparam int LAT  = 1;
    localparam int FL_N = 2;
`else
    localparam int LAT  = 2;
    localparam int FL_N = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic        req0_vec = 1'b0, req1_vec = 1'b0;
    logic [2:0]  req0_dir = '0, req1_dir = '0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic        reg_wrv, reg_wrs, wb_idle;
    logic [2:0]  i_dir_wr;
    logic [31:0] data_wrv;
    logic [7:0]  data_wrs;

    int total = 0;
    int bad   = 0;
    logic [35:0] wlog [$];

    wb_arbiter #(.FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_vec(req0_vec),
        .req0_dir(req0_dir), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_vec(req1_vec),
        .req1_dir(req1_dir), .req1_data(req1_data),
        .reg_wrv(reg_wrv), .reg_wrs(reg_wrs), .i_dir_wr(i_dir_wr),
        .data_wrv(data_wrv), .data_wrs(data_wrs), .wb_idle(wb_idle)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wrv || reg_wrs) wlog.push_back({reg_wrv, i_dir_wr, data_wrv});
    end

    task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] wl(input int i);
        return (i < wlog.size()) ? wlog[i] : 36'hF_FFFF_FFFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [35:0] ent0(input int i);
        return {1'b1, 3'(i), 32'h0000_00A0 + 32'(i)};
    endfunction

    function automatic logic [35:0] ent1(input int i);
        return {1'b1, 3'(4 + i), 32'h0000_00B0 + 32'(i)};
    endfunction

    // Streams n0/n1 vector writes with handshakes; reports whether req1 was ever held off.
    task automatic stream(input int n0, input int n1, output int stall1);
        int i0 = 0, i1 = 0, cyc = 0;
        logic a0, a1;
        stall1 = 0;
        while ((i0 < n0 || i1 < n1) && cyc < 100) begin
            req0_valid = (i0 < n0);
            {req0_vec, req0_dir, req0_data} = ent0(i0);
            req1_valid = (i1 < n1);
            {req1_vec, req1_dir, req1_data} = ent1(i1);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            if (req1_valid && !req1_ready) stall1 = 1;
            tick();
            if (a0) i0++;
            if (a1) i1++;
            cyc++;
        end
        check_eq("stream_done", 36'((i0 == n0) && (i1 == n1)), 36'd1);
        idle_inputs();
    endtask

    initial begin
        int stall1, n;
        logic [35:0] q0 [$];
        logic [35:0] q1 [$];

        // Reset state
        repeat (2) tick();
        check_eq("rst_wrv", reg_wrv, 0);
        check_eq("rst_wrs", reg_wrs, 0);
        check_eq("rst_dir", i_dir_wr, 0);
        check_eq("rst_data", data_wrv, 0);
        check_eq("rst_rdy0", req0_ready, 1);
        check_eq("rst_rdy1", req1_ready, 1);
        check_eq("rst_idle", wb_idle, 1);
        rst_n = 1'b1;
        tick();

        // Single scalar write
        req0_valid = 1'b1; req0_vec = 1'b0; req0_dir = 3'd5; req0_data = 32'h1234_56A7;
        tick();
        idle_inputs();
        repeat (LAT - 1) tick();
        check_eq("single_wrs", reg_wrs, 1);
        check_eq("single_wrv", reg_wrv, 0);
        check_eq("single_dir", i_dir_wr, 5);
        check_eq("single_data", data_wrs, 8'hA7);
        tick();
        check_eq("single_wrs_off", reg_wrs, 0);
        check_eq("single_idle", wb_idle, 1);

        // Contention: grants alternate starting with requester 0
        do_reset();
        wlog.delete();
        stream(3, 3, stall1);
        repeat (8) tick();
        check_eq("cont_count", wlog.size(), 6);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("cont_r0_%0d", i), wl(2 * i), ent0(i));
            check_eq($sformatf("cont_r1_%0d", i), wl(2 * i + 1), ent1(i));
        end
        check_eq("cont_idle", wb_idle, 1);

        // Backpressure: req1 is held off under contention, nothing lost or duplicated
        do_reset();
        wlog.delete();
        stream(6, 4, stall1);
        repeat (12) tick();
        check_eq("bp_stall1", stall1, 1);
        foreach (wlog[i]) begin
            if (wlog[i][7:4] == 4'hA) q0.push_back(wlog[i]);
            else q1.push_back(wlog[i]);
        end
        check_eq("bp_n0", q0.size(), 6);
        check_eq("bp_n1", q1.size(), 4);
        n = (q0.size() < 6) ? q0.size() : 6;
        for (int i = 0; i < n; i++) check_eq($sformatf("bp_r0_%0d", i), q0[i], ent0(i));
        n = (q1.size() < 4) ? q1.size() : 4;
        for (int i = 0; i < n; i++) check_eq($sformatf("bp_r1_%0d", i), q1[i], ent1(i));
        check_eq("bp_idle", wb_idle, 1);

        // Flush mid-stream with pushes in the flush cycle
        do_reset();
        wlog.delete();
        for (int i = 0; i < 2; i++) begin
            req0_valid = 1'b1; {req0_vec, req0_dir, req0_data} = ent0(i);
            req1_valid = 1'b1; {req1_vec, req1_dir, req1_data} = ent1(i);
            tick();
        end
        flush = 1'b1;
        req0_dir = 3'd7; req0_data = 32'hFF; req1_dir = 3'd7; req1_data = 32'hFF;
        tick();
        idle_inputs();
        check_eq("fl_wrv", reg_wrv, 0);
        check_eq("fl_wrs", reg_wrs, 0);
        check_eq("fl_idle", wb_idle, 1);
        check_eq("fl_rdy0", req0_ready, 1);
        check_eq("fl_rdy1", req1_ready, 1);
        repeat (4) tick();
        check_eq("fl_idle_late", wb_idle, 1);
        check_eq("fl_count", wlog.size(), FL_N);
        check_eq("fl_first", wl(0), ent0(0));

        // Asynchronous reset while a vector write is on the port
        req0_valid = 1'b1; {req0_vec, req0_dir, req0_data} = ent0(3);
        tick();
        idle_inputs();
        n = 0;
        while (!reg_wrv && n < 10) begin
            tick();
            n++;
        end
        check_eq("ar_pre_wrv", reg_wrv, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_wrv", reg_wrv, 0);
        check_eq("ar_idle", wb_idle, 1);
        check_eq("ar_rdy0", req0_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        wlog.delete();
        req0_valid = 1'b1; {req0_vec, req0_dir, req0_data} = ent0(1);
        req1_valid = 1'b1; {req1_vec, req1_dir, req1_data} = ent1(1);
        tick();
        idle_inputs();
        repeat (5) tick();
        check_eq("ar_count", wlog.size(), 2);
        check_eq("ar_first", wl(0), ent0(1));
        check_eq("ar_second", wl(1), ent1(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the shared register-bank write port of the decode stage. It accepts write requests from two producers, the vector ALU path (requester 0) and the memory load path (requester 1), each into its own small FIFO. It then issues at most one write per cycle to the vector or scalar bank through registered strobes, address and data. Per-requester order is preserved. Requests are granted round-robin when both FIFOs hold entries.

## Interface
- `FIFO_DEPTH`, default 2: entries per requester FIFO; power of two, ≥ 2.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `flush`, input, 1: synchronous; drops all queued and in-flight writes.
- `req0_valid` / `req1_valid`, input, 1 each: request present.
- `req0_ready` / `req1_ready`, output, 1 each: FIFO can accept.
- `req0_vec` / `req1_vec`, input, 1 each: 1 = vector bank, 0 = scalar bank.
- `req0_dir` / `req1_dir`, input, 3 each: destination register.
- `req0_data` / `req1_data`, input, 32 each: write data; scalar uses [7:0].
- `reg_wrv`, output, 1: vector bank write strobe.
- `reg_wrs`, output, 1: scalar bank write strobe.
- `i_dir_wr`, output, 3: write address.
- `data_wrv`, output, 32: vector write data.
- `data_wrs`, output, 8: scalar write data.
- `wb_idle`, output, 1: both FIFOs empty and no strobe asserted.

## Operation
- Push:
  - Requester k pushes {vec, dir, data} on an edge where `reqk_valid` and `reqk_ready` are both 1.
  - `reqk_ready` = (countk < FIFO_DEPTH). It depends on the count only: a full FIFO does not accept in a cycle in which it is popped.
- Candidates: every non-empty FIFO head.
- Arbiter:
  - 1-bit `last` register; reset value 1, so requester 0 wins first.
  - One candidate: it is granted.
  - Two candidates: the requester ≠ `last` is granted.
  - `last` updates to the granted requester on every grant.
  - No grant leaves `last` unchanged.
- Issue:
  - The granted head is popped.
  - On the same edge the output register loads:
    - `reg_wrv` = vec, `reg_wrs` = !vec;
    - `i_dir_wr` = dir;
    - `data_wrv` = data, `data_wrs` = data[7:0].
  - No grant: both strobes load 0. Address and data hold their previous values.
- Strobes are mutually exclusive, at most one write per cycle.
- Push and pop on the same edge in one FIFO leave the count unchanged. Read and write pointers wrap modulo FIFO_DEPTH.
- Flush:
  - Clears both counts and pointers, and loads both strobes to 0 on that edge.
  - Pushes presented in the flush cycle are discarded.
  - `last` is preserved.
- `wb_idle` = (count0 == 0) & (count1 == 0) & !`reg_wrv` & !`reg_wrs`.
- Ordering between requesters is not enforced. WAW ordering across the ALU and load paths is the issue logic's responsibility.

## Timing
- Reset (asynchronous, any time, including mid-burst):
  - Counts, pointers, `reg_wrv`, `reg_wrs`, `i_dir_wr` and `data_wrv` / `data_wrs` go to 0.
  - `last` goes to 1.
  - While in reset: `req0_ready` = `req1_ready` = 1, `wb_idle` = 1.
- Latency:
  - Push at edge E0 → output register loads at E1 → strobe high in the cycle after E1.
  - Latency is 2 edges with the bypass absent or not applicable.
- Throughput: one write per cycle sustained. Both requesters streaming alternate 0,1,0,1.
- A full FIFO with continuous pops and pushes sustains 1 entry per cycle only for FIFO_DEPTH ≥ 2; this is why the minimum depth is 2.

## Configuration
- `WB_BYPASS_EN` defined:
  - A valid request whose FIFO is empty (and not being pushed from the queue) joins as a candidate directly.
  - If granted, it loads the output register at the accepting edge E0, without entering the FIFO. Latency is 1 edge.
  - If not granted, it is pushed normally.
  - Flush still discards it.
- `WB_BYPASS_EN` undefined: every request goes through its FIFO; latency is fixed at 2 edges.

## Test plan
- Single scalar write:
  - Stimulus: after reset, req0 = {vec 0, dir 5, data 0x1234_56A7} for one cycle.
  - Required: `reg_wrs` = 1, `i_dir_wr` = 5, `data_wrs` = 0xA7 two edges later (one with bypass); `wb_idle` then returns to 1.
- Contention:
  - Stimulus: req0 and req1 each push 3 vector writes in the same cycles.
  - Required: grant order 0,1,0,1,0,1; each requester's dirs appear in push order.
- Backpressure:
  - Stimulus: FIFO_DEPTH = 2; hold req1 valid 4 cycles while req0's FIFO keeps winning against an empty req1... then make req0 continuously non-empty and check `req1_ready`.
  - Required: `req1_ready` drops after 2 accepts with contention; no entry is lost or duplicated.
- Flush mid-stream:
  - Stimulus: 2 entries queued in each FIFO; assert `flush` with new pushes in the same cycle.
  - Required: no strobe the next cycle; counts 0; the flush-cycle pushes are never written; `wb_idle` = 1.
- Reset mid-operation:
  - Stimulus: assert `rst_n` = 0 asynchronously while `reg_wrv` = 1.
  - Required: `reg_wrv` drops immediately; after release the first contended grant goes to requester 0.
